// File: rtl/clock_time_keeper.sv
// HH:MM:SS BCD timekeeper with button-driven setting and blink/blank control
// for a 6-digit 7-segment display driver.
module clock_time_keeper #(
    parameter int CLK_RATE_HZ   = 390625,
    parameter int BLINK_RATE_HZ = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        btn_mode,
    input  logic        btn_inc,
    output logic [23:0] data,
    output logic [5:0]  digit_enable_mask,
    output logic [5:0]  decimal_point_enable_mask,
    output logic        second_tick
);

    localparam int BLINK_HALF = CLK_RATE_HZ / (2 * BLINK_RATE_HZ);
    localparam int PW = (CLK_RATE_HZ > 2) ? $clog2(CLK_RATE_HZ) : 1;
    localparam int BW = (BLINK_HALF > 2) ? $clog2(BLINK_HALF) : 1;
    localparam logic [PW-1:0] PRESC_MAX  = PW'(CLK_RATE_HZ - 1);
    localparam logic [PW-1:0] PRESC_HALF = PW'(CLK_RATE_HZ / 2);
    localparam logic [BW-1:0] BLINK_MAX  = BW'(BLINK_HALF - 1);

    typedef enum logic [1:0] {
        RUN         = 2'd0,
        SET_HOURS   = 2'd1,
        SET_MINUTES = 2'd2,
        SET_SECONDS = 2'd3
    } state_t;

    state_t         state_q, state_d;
    logic [PW-1:0]  presc_q, presc_d;
    logic [BW-1:0]  blink_cnt_q, blink_cnt_d;
    logic           blink_hidden_q, blink_hidden_d;
    logic [7:0]     sec_q, sec_d;
    logic [7:0]     min_q, min_d;
    logic [7:0]     hr_q, hr_d;
    logic           second_tick_q, second_tick_d;
    logic [5:0]     digit_en_q, digit_en_d;
    logic [5:0]     dp_en_q, dp_en_d;
    logic           wrap;

    // Two-digit BCD increments; both wrap to 00 without producing illegal codes.
    function automatic logic [7:0] bcd_inc60(input logic [7:0] v);
        if (v[3:0] != 4'd9)
            return {v[7:4], v[3:0] + 4'd1};
        else if (v[7:4] != 4'd5)
            return {v[7:4] + 4'd1, 4'd0};
        else
            return 8'h00;
    endfunction

    function automatic logic [7:0] bcd_inc24(input logic [7:0] v);
        if (v == 8'h23)
            return 8'h00;
        else if (v[3:0] == 4'd9)
            return {v[7:4] + 4'd1, 4'd0};
        else
            return {v[7:4], v[3:0] + 4'd1};
    endfunction

    always_comb begin
        state_d        = state_q;
        presc_d        = presc_q;
        blink_cnt_d    = blink_cnt_q;
        blink_hidden_d = blink_hidden_q;
        sec_d          = sec_q;
        min_d          = min_q;
        hr_d           = hr_q;

        wrap = (state_q == RUN) && (presc_q == PRESC_MAX);

        if (state_q == RUN)
            presc_d = wrap ? '0 : presc_q + PW'(1);
        else
            presc_d = '0;

        if (wrap) begin
            sec_d = bcd_inc60(sec_q);
            if (sec_q == 8'h59) begin
                min_d = bcd_inc60(min_q);
                if (min_q == 8'h59)
                    hr_d = bcd_inc24(hr_q);
            end
        end

        // Mode beats inc; any accepted press restarts the blink with the field visible.
        if (btn_mode) begin
            case (state_q)
                RUN:         state_d = SET_HOURS;
                SET_HOURS:   state_d = SET_MINUTES;
                SET_MINUTES: state_d = SET_SECONDS;
                default:     state_d = RUN;
            endcase
            blink_cnt_d    = '0;
            blink_hidden_d = 1'b0;
        end else if (btn_inc && state_q != RUN) begin
            case (state_q)
                SET_HOURS:   hr_d  = bcd_inc24(hr_q);
                SET_MINUTES: min_d = bcd_inc60(min_q);
                default:     sec_d = 8'h00;
            endcase
            blink_cnt_d    = '0;
            blink_hidden_d = 1'b0;
        end else if (state_q != RUN) begin
            if (blink_cnt_q == BLINK_MAX) begin
                blink_cnt_d    = '0;
                blink_hidden_d = ~blink_hidden_q;
            end else begin
                blink_cnt_d = blink_cnt_q + BW'(1);
            end
        end else begin
            blink_cnt_d    = '0;
            blink_hidden_d = 1'b0;
        end

        digit_en_d = 6'b111111;
        if (hr_q[7:4] == 4'd0)
            digit_en_d[5] = 1'b0;
        if (blink_hidden_q) begin
            case (state_q)
                SET_HOURS:   digit_en_d[5:4] = 2'b00;
                SET_MINUTES: digit_en_d[3:2] = 2'b00;
                SET_SECONDS: digit_en_d[1:0] = 2'b00;
                default:     ;
            endcase
        end

        dp_en_d = ((state_q != RUN) || (presc_q < PRESC_HALF)) ? 6'b010100 : 6'b000000;
        second_tick_d = wrap;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q        <= RUN;
            presc_q        <= '0;
            blink_cnt_q    <= '0;
            blink_hidden_q <= 1'b0;
            sec_q          <= 8'h00;
            min_q          <= 8'h00;
            hr_q           <= 8'h00;
            second_tick_q  <= 1'b0;
            digit_en_q     <= 6'b011111;
            dp_en_q        <= 6'b010100;
        end else begin
            state_q        <= state_d;
            presc_q        <= presc_d;
            blink_cnt_q    <= blink_cnt_d;
            blink_hidden_q <= blink_hidden_d;
            sec_q          <= sec_d;
            min_q          <= min_d;
            hr_q           <= hr_d;
            second_tick_q  <= second_tick_d;
            digit_en_q     <= digit_en_d;
            dp_en_q        <= dp_en_d;
        end
    end

    assign data                      = {hr_q, min_q, sec_q};
    assign digit_enable_mask         = digit_en_q;
    assign decimal_point_enable_mask = dp_en_q;
    assign second_tick               = second_tick_q;

endmodule
